// File: rtl/dram_arb.sv
// Two-requester (CPU / SPI host) arbiter in front of a single-port DRAM, with zero-latency grant and bounded bursts.
// Optional macro DRAM_ARB_RR_EN: round-robin tie break in IDLE and burst limit on both owners (default: host priority).
module dram_arb #(
    parameter int XLEN      = 32,
    parameter int MAX_BURST = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            cpu_req_i,
    input  logic            cpu_we_i,
    input  logic [XLEN-1:0] cpu_addr_i,
    input  logic [XLEN-1:0] cpu_wdata_i,
    input  logic [3:0]      cpu_be_i,
    output logic            cpu_gnt_o,
    output logic            cpu_rvld_o,
    output logic [XLEN-1:0] cpu_rdata_o,
    input  logic            host_req_i,
    input  logic            host_we_i,
    input  logic [XLEN-1:0] host_addr_i,
    input  logic [XLEN-1:0] host_wdata_i,
    input  logic [3:0]      host_be_i,
    output logic            host_gnt_o,
    output logic            host_rvld_o,
    output logic [XLEN-1:0] host_rdata_o,
    output logic            mem_en_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic [3:0]      mem_be_o,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic            busy_o
);

    localparam int CW = $clog2(MAX_BURST) + 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, CPU_OWN, HOST_OWN} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   burst_cnt, burst_nxt;
    logic            pick_cpu, pick_host;
    logic            cpu_rvld_q, host_rvld_q;
    logic [XLEN-1:0] cpu_rdata_q, host_rdata_q;
`ifdef DRAM_ARB_RR_EN
    logic            last_host;
`endif

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        pick_cpu  = 1'b0;
        pick_host = 1'b0;
        case (state)
            CPU_OWN: begin
                if (cpu_req_i && (!host_req_i || burst_cnt < MAX_CNT)) pick_cpu  = 1'b1;
                else if (host_req_i)                                    pick_host = 1'b1;
            end
            HOST_OWN: begin
`ifdef DRAM_ARB_RR_EN
                if (host_req_i && (!cpu_req_i || burst_cnt < MAX_CNT)) pick_host = 1'b1;
                else if (cpu_req_i)                                     pick_cpu  = 1'b1;
`else
                if (host_req_i)     pick_host = 1'b1;
                else if (cpu_req_i) pick_cpu  = 1'b1;
`endif
            end
            default: begin
                if (cpu_req_i && host_req_i) begin
`ifdef DRAM_ARB_RR_EN
                    pick_cpu  = last_host;
                    pick_host = !last_host;
`else
                    pick_host = 1'b1;
`endif
                end else begin
                    pick_cpu  = cpu_req_i;
                    pick_host = host_req_i;
                end
            end
        endcase
    end

    // A grant to the current owner extends its burst; a grant to the other side restarts it at 1.
    always_comb begin
        state_nxt = IDLE;
        burst_nxt = '0;
        if (pick_cpu) begin
            state_nxt = CPU_OWN;
            burst_nxt = (state != CPU_OWN) ? CW'(1) :
                        (burst_cnt == MAX_CNT) ? MAX_CNT : burst_cnt + CW'(1);
        end else if (pick_host) begin
            state_nxt = HOST_OWN;
            burst_nxt = (state != HOST_OWN) ? CW'(1) :
                        (burst_cnt == MAX_CNT) ? MAX_CNT : burst_cnt + CW'(1);
        end
    end

    // Grants are killed by reset itself, not by the registered state, so they drop the instant rst_i rises.
    assign cpu_gnt_o  = pick_cpu  && !rst_i;
    assign host_gnt_o = pick_host && !rst_i;
    assign mem_en_o   = cpu_gnt_o | host_gnt_o;
    assign busy_o     = (state != IDLE);

    always_comb begin
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = 4'b0000;
        if (cpu_gnt_o) begin
            mem_we_o    = cpu_we_i;
            mem_addr_o  = cpu_addr_i;
            mem_wdata_o = cpu_wdata_i;
            mem_be_o    = cpu_we_i ? cpu_be_i : 4'b0000;
        end else if (host_gnt_o) begin
            mem_we_o    = host_we_i;
            mem_addr_o  = host_addr_i;
            mem_wdata_o = host_wdata_i;
            mem_be_o    = host_we_i ? host_be_i : 4'b0000;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            burst_cnt    <= '0;
            cpu_rvld_q   <= 1'b0;
            host_rvld_q  <= 1'b0;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            state       <= state_nxt;
            burst_cnt   <= burst_nxt;
            cpu_rvld_q  <= cpu_gnt_o  && !cpu_we_i;
            host_rvld_q <= host_gnt_o && !host_we_i;
            if (cpu_rvld_q)  cpu_rdata_q  <= mem_rdata_i;
            if (host_rvld_q) host_rdata_q <= mem_rdata_i;
        end
    end

`ifdef DRAM_ARB_RR_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)          last_host <= 1'b1;
        else if (pick_cpu)  last_host <= 1'b0;
        else if (pick_host) last_host <= 1'b1;
    end
`endif

    // Read data passes straight through in the valid cycle and is held from the capture register afterwards.
    assign cpu_rvld_o   = cpu_rvld_q;
    assign host_rvld_o  = host_rvld_q;
    assign cpu_rdata_o  = cpu_rvld_q  ? mem_rdata_i : cpu_rdata_q;
    assign host_rdata_o = host_rvld_q ? mem_rdata_i : host_rdata_q;

endmodule

// File: tb/tb_dram_arb.sv
// Self-checking bench for dram_arb: directed scenarios then random traffic against a transaction-level model.
// Honours DRAM_ARB_RR_EN the same way the design does.
module tb_dram_arb;

    localparam int XLEN = 32;
    localparam int MB   = 4;
    localparam int NONE = 0, CPU = 1, HOST = 2;

    typedef struct {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, host_req, host_we;
    logic [31:0] cpu_addr, cpu_wdata, host_addr, host_wdata;
    logic [3:0]  cpu_be, host_be;
    logic        cpu_gnt, cpu_rvld, host_gnt, host_rvld;
    logic [31:0] cpu_rdata, host_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        busy;

    always #5 clk = ~clk;

    dram_arb #(.XLEN(XLEN), .MAX_BURST(MB)) dut (
        .clk_i(clk), .rst_i(rst),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
        .cpu_wdata_i(cpu_wdata), .cpu_be_i(cpu_be),
        .cpu_gnt_o(cpu_gnt), .cpu_rvld_o(cpu_rvld), .cpu_rdata_o(cpu_rdata),
        .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr),
        .host_wdata_i(host_wdata), .host_be_i(host_be),
        .host_gnt_o(host_gnt), .host_rvld_o(host_rvld), .host_rdata_o(host_rdata),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_rdata_i(mem_rdata),
        .busy_o(busy)
    );

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'hDEAD_BEEF : 32'h1000_0000 + 32'(i) * 32'h0101_0101;
    endfunction

    // Synchronous single-port DRAM with one-cycle read latency, driven only by the DUT's memory port.
    logic [31:0] ram [16];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) ram[i] <= init_word(i);
            mem_rdata <= '0;
        end else if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) ram[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= ram[mem_addr[5:2]];
            end
        end
    end

    // Reference model: who owns the memory, how long they have held it, and what each side should read back.
    int          m_owner, m_run;
`ifdef DRAM_ARB_RR_EN
    int          m_last;
`endif
    logic [31:0] ref_mem [16];
    logic        exp_crvld, exp_hrvld;
    logic [31:0] exp_crdata, exp_hrdata, hold_c, hold_h;
    txn_t        cpu_t, host_t;
    int          n_checks = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = NONE;
        m_run   = 0;
`ifdef DRAM_ARB_RR_EN
        m_last  = HOST;
`endif
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
        exp_crvld = 1'b0; exp_hrvld = 1'b0;
        exp_crdata = '0;  exp_hrdata = '0;
        hold_c = '0;      hold_h = '0;
    endtask

    // Winner for this cycle given the policy: owner keeps it until it stops or exhausts its burst against a waiter.
    function automatic int pick(input logic c, input logic h);
        if (m_owner == CPU && c && (!h || m_run < MB)) return CPU;
`ifdef DRAM_ARB_RR_EN
        if (m_owner == HOST && h && (!c || m_run < MB)) return HOST;
`else
        if (m_owner == HOST && h) return HOST;
`endif
        if (c && h) begin
            if (m_owner == CPU)  return HOST;
            if (m_owner == HOST) return CPU;
`ifdef DRAM_ARB_RR_EN
            return (m_last == CPU) ? HOST : CPU;
`else
            return HOST;
`endif
        end
        if (c) return CPU;
        if (h) return HOST;
        return NONE;
    endfunction

    // Called on a falling edge: drive the two requests, then compare everything visible in this cycle.
    task automatic eval_cycle(output int win);
        txn_t t;
        cpu_req  = cpu_t.req;  cpu_we  = cpu_t.we;  cpu_addr  = cpu_t.addr;
        cpu_wdata = cpu_t.wdata; cpu_be = cpu_t.be;
        host_req = host_t.req; host_we = host_t.we; host_addr = host_t.addr;
        host_wdata = host_t.wdata; host_be = host_t.be;
        #1;
        win = rst ? NONE : pick(cpu_t.req, host_t.req);
        chk("cpu_gnt",    cpu_gnt,    win == CPU);
        chk("host_gnt",   host_gnt,   win == HOST);
        chk("mem_en",     mem_en,     win != NONE);
        chk("busy",       busy,       m_owner != NONE);
        chk("cpu_rvld",   cpu_rvld,   exp_crvld);
        chk("host_rvld",  host_rvld,  exp_hrvld);
        chk("cpu_rdata",  cpu_rdata,  exp_crdata);
        chk("host_rdata", host_rdata, exp_hrdata);
        chk("burst_cnt",  dut.burst_cnt, m_run);
        if (win != NONE) begin
            t = (win == CPU) ? cpu_t : host_t;
            chk("mem_we",   mem_we,   t.we);
            chk("mem_addr", mem_addr, t.addr);
            chk("mem_be",   mem_be,   t.we ? t.be : 4'b0000);
            if (t.we) chk("mem_wdata", mem_wdata, t.wdata);
        end else begin
            chk("mem_we_idle", mem_we, 1'b0);
        end
    endtask

    task automatic advance(input int win);
        txn_t        t;
        logic [31:0] a;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (exp_crvld) hold_c = exp_crdata;
            if (exp_hrvld) hold_h = exp_hrdata;
            t = (win == CPU) ? cpu_t : host_t;
            a = t.addr;
            exp_crvld  = (win == CPU)  && !cpu_t.we;
            exp_hrvld  = (win == HOST) && !host_t.we;
            exp_crdata = exp_crvld ? ref_mem[a[5:2]] : hold_c;
            exp_hrdata = exp_hrvld ? ref_mem[a[5:2]] : hold_h;
            if (win != NONE && t.we)
                for (int b = 0; b < 4; b++)
                    if (t.be[b]) ref_mem[a[5:2]][8*b +: 8] = t.wdata[8*b +: 8];
            if (win == NONE) begin
                m_owner = NONE;
                m_run   = 0;
            end else if (win == m_owner) begin
                m_run = (m_run < MB) ? m_run + 1 : MB;
            end else begin
                m_owner = win;
                m_run   = 1;
`ifdef DRAM_ARB_RR_EN
                m_last  = win;
`endif
            end
        end
        @(negedge clk);
    endtask

    task automatic step(output int win);
        eval_cycle(win);
        advance(win);
    endtask

    function automatic txn_t rand_txn();
        txn_t t;
        t.req   = 1'b1;
        t.we    = 1'($urandom_range(0, 1));
        t.addr  = $urandom & 32'h0000_00FC;
        t.wdata = $urandom;
        t.be    = 4'($urandom);
        return t;
    endfunction

    initial begin
        int win;
        rst    = 1'b1;
        cpu_t  = '{1'b1, 1'b0, 32'h4, 32'h0, 4'hF};
        host_t = '{1'b1, 1'b0, 32'h8, 32'h0, 4'hF};
        model_reset();
        @(negedge clk);
        // Requests held during reset must never be granted.
        repeat (2) step(win);
        rst = 1'b0;

        // Both requesters hammer from reset with reads.
`ifdef DRAM_ARB_RR_EN
        for (int i = 0; i < 16; i++) begin
            eval_cycle(win);
            chk("rr_cpu_turn", cpu_gnt, ((i / MB) % 2) == 0);
            advance(win);
        end
`else
        for (int i = 0; i < 8; i++) begin
            eval_cycle(win);
            chk("prio_host_only", host_gnt, 1'b1);
            chk("prio_cpu_waits", cpu_gnt,  1'b0);
            advance(win);
        end
        host_t.req = 1'b0;
        eval_cycle(win);
        chk("prio_cpu_after_drop", cpu_gnt, 1'b1);
        advance(win);
`endif
        cpu_t.req = 1'b0; host_t.req = 1'b0;
        step(win);
        step(win);

        // CPU read alone, then the returned word.
        cpu_t = '{1'b1, 1'b0, 32'h10, 32'h0, 4'hF};
        eval_cycle(win);
        chk("cpu_read_gnt", cpu_gnt, 1'b1);
        advance(win);
        cpu_t.req = 1'b0;
        chk("cpu_read_rvld",  cpu_rvld,  1'b1);
        chk("cpu_read_data",  cpu_rdata, 32'hDEAD_BEEF);
        chk("cpu_read_hrvld", host_rvld, 1'b0);
        step(win);

        // Host byte write, then CPU reads the merged word back.
        host_t = '{1'b1, 1'b1, 32'h20, 32'h00AB_0000, 4'b0100};
        eval_cycle(win);
        chk("host_wr_en", mem_en, 1'b1);
        chk("host_wr_we", mem_we, 1'b1);
        chk("host_wr_be", mem_be, 4'b0100);
        chk("host_wr_cpu_gnt", cpu_gnt, 1'b0);
        advance(win);
        host_t.req = 1'b0;
        chk("host_wr_no_rvld", host_rvld, 1'b0);
        cpu_t = '{1'b1, 1'b0, 32'h20, 32'h0, 4'hF};
        step(win);
        cpu_t.req = 1'b0;
        chk("host_wr_merged", cpu_rdata, (init_word(8) & 32'hFF00_FFFF) | 32'h00AB_0000);
        step(win);

        // Owner drop: three CPU reads while the host waits, then the host takes over with no idle cycle.
        cpu_t = '{1'b1, 1'b0, 32'h0, 32'h0, 4'hF};
        step(win);
        host_t = '{1'b1, 1'b0, 32'h4, 32'h0, 4'hF};
        step(win);
        step(win);
        cpu_t.req = 1'b0;
        eval_cycle(win);
        chk("drop_host_gnt", host_gnt, 1'b1);
        advance(win);
        chk("drop_burst_one", dut.burst_cnt, 32'd1);
        chk("drop_busy", busy, 1'b1);
        host_t.req = 1'b0;
        step(win);
        step(win);

        // Reset lands in the cycle right after a granted read.
        cpu_t = '{1'b1, 1'b0, 32'h10, 32'h0, 4'hF};
        eval_cycle(win);
        chk("rst_mid_gnt", cpu_gnt, 1'b1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_mid_rvld", cpu_rvld, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_gnt_low", cpu_gnt, 1'b0);
        chk("rst_mid_en_low", mem_en, 1'b0);
        @(negedge clk);
        step(win);
        rst = 1'b0;
        eval_cycle(win);
        chk("post_rst_gnt", cpu_gnt, 1'b1);
        advance(win);
        cpu_t.req = 1'b0;
        step(win);

        // Random traffic; an ungranted request is held unchanged until it is served.
        for (int i = 0; i < 1500; i++) begin
            if (!cpu_t.req  && $urandom_range(0, 3) != 0) cpu_t  = rand_txn();
            if (!host_t.req && $urandom_range(0, 3) != 0) host_t = rand_txn();
            step(win);
            if (win == CPU) begin
                if ($urandom_range(0, 3) != 0) cpu_t = rand_txn();
                else cpu_t.req = 1'b0;
            end
            if (win == HOST) begin
                if ($urandom_range(0, 3) != 0) host_t = rand_txn();
                else host_t.req = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
